// File: rtl/apb_pkg.sv
// Shared definitions for the APB3 requester: FSM state encoding, bus widths
// and the command-address bit that picks between the two slaves.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W  = 7;
  localparam int APB_DATA_W  = 8;
  localparam int SLV_SEL_BIT = 7;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait-state counter. It clears while the master is in SETUP,
// so it starts from zero on entry to ACCESS. It then counts ACCESS cycles in
// which the selected slave holds PREADY low. 'hit' marks the wait cycle that
// brings the count to LIMIT.
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic hit
);

  logic [7:0] count;

  // Count wait states; restart for every new transfer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  // The current cycle is a wait cycle and it is the LIMIT-th one.
  assign hit = tick && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester in front of two slaves.
// Address bit 7 picks the slave; the low 7 bits become PADDR.
// When APB_MASTER_TIMEOUT_EN is defined, a transfer whose ACCESS phase sees
// TIMEOUT_CYCLES wait states is aborted with rsp_err = 1.
// When it is not defined, ACCESS waits for PREADY indefinitely.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [7:0]            req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELECT1,
  output logic                  PSELECT2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA1,
  input  logic [APB_DATA_W-1:0] PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2,
  input  logic                  PSLVERR1,
  input  logic                  PSLVERR2
);

  apb_state_t            state;
  logic                  sel_ready;
  logic                  sel_slverr;
  logic [APB_DATA_W-1:0] sel_rdata;
  logic                  timeout_hit;

  // Reject an illegal wait-state limit at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  // Listen only to the slave currently being addressed.
  // PSELECT2 stays stable for the whole transfer, so it acts as the decode.
  assign sel_ready  = PSELECT2 ? PREADY2  : PREADY1;
  assign sel_slverr = PSELECT2 ? PSLVERR2 : PSLVERR1;
  assign sel_rdata  = PSELECT2 ? PRDATA2  : PRDATA1;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk   (PCLK),
    .rst   (PRESET),
    .clear (state == SETUP),
    .tick  ((state == ACCESS) && !sel_ready),
    .hit   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Transfer sequencer. All outputs are registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSELECT1  <= 1'b0;
      PSELECT2  <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block to the
      // same register wins, which turns rsp_valid into a one-cycle strobe.
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= SETUP;
            req_ready <= 1'b0;
            PWRITE    <= req_write;
            PADDR     <= req_addr[APB_ADDR_W-1:0];
            PWDATA    <= req_wdata;
            PSELECT1  <= ~req_addr[SLV_SEL_BIT];
            PSELECT2  <= req_addr[SLV_SEL_BIT];
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (sel_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : sel_rdata;
            rsp_err   <= sel_slverr;
            PSELECT1  <= 1'b0;
            PSELECT2  <= 1'b0;
            PENABLE   <= 1'b0;
          end else if (timeout_hit) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            PSELECT1  <= 1'b0;
            PSELECT2  <= 1'b0;
            PENABLE   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB3 requester (bridge) that sits directly upstream of the APB slaves (Slave1, Slave2). It takes one read or write request at a time from a simple valid/ready command port, runs the APB SETUP/ACCESS sequence, and returns read data and error status on a one-cycle response strobe. The top address bit decodes which of the two slave selects is driven.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: ACCESS-phase wait-state limit; only used when APB_MASTER_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- PCLK  input  1  sole clock; all state updates on the rising edge.
- PRESET  input  1  reset; synchronous, active-high.
- req_valid  input  1  command present.
- req_ready  output  1  master can accept a command.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  8  bit 7 selects the slave (0 = slave 1, 1 = slave 2); bits 6:0 are the slave address.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle completion strobe.
- rsp_rdata  output  8  read data; 0 for writes and aborted transfers.
- rsp_err  output  1  slave error or timeout; qualified by rsp_valid.
- PSELECT1, PSELECT2  output  1 each  APB selects; at most one is high.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  7  APB address.
- PWDATA  output  8  APB write data.
- PRDATA1, PRDATA2  input  8 each  slave read data.
- PREADY1, PREADY2  input  1 each  slave ready.
- PSLVERR1, PSLVERR2  input  1 each  slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_write, req_addr and req_wdata, then go to SETUP.
- SETUP:
  - PSELECTx = 1 for the decoded slave; PENABLE = 0.
  - Always go to ACCESS on the next cycle.
- ACCESS:
  - PSELECTx = 1; PENABLE = 1.
  - Sample the selected slave's PREADY, PRDATA and PSLVERR only; the other slave's inputs are ignored.
  - PREADY = 1: register rsp_rdata (PRDATA for reads, 0 for writes) and rsp_err = PSLVERR, pulse rsp_valid next cycle, go to IDLE.
  - PREADY = 0: stay in ACCESS.
- PADDR, PWRITE and PWDATA are driven from the latched command and stay stable from SETUP through the final ACCESS cycle.
- In IDLE they hold their last values, but PSELECT1/2 and PENABLE are 0.
- There are no back-to-back transfers: IDLE always lasts at least one cycle between transfers.
- req_valid arriving outside IDLE is not accepted (req_ready = 0); the requester must hold it.
- Reset, including mid-transfer: state returns to IDLE. Every output resets to 0, except req_ready, which is 1 in the first cycle after reset. Any in-flight transfer is dropped and no rsp_valid is issued for it.

## Timing
- Handshake: a command is accepted at edge 0 when req_valid = 1 and req_ready = 1.
- Cycle 1: SETUP.
- Cycle 2: ACCESS.
- With a zero-wait slave (PREADY = 1 in cycle 2), rsp_valid = 1 and req_ready = 1 in cycle 3.
- Total latency from acceptance to rsp_valid is 3 + W cycles, where W is the number of wait states.
- rsp_valid is high for exactly one cycle. rsp_rdata and rsp_err hold their values until the next completion.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES and PREADY is still 0, the transfer aborts: PSELECTx and PENABLE drop next cycle, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, and the FSM goes to IDLE.
  - If PREADY = 1 in the same cycle the limit is reached, the transfer completes normally.
- APB_MASTER_TIMEOUT_EN undefined: the counter is not built and ACCESS waits indefinitely.

## Structure
- Shared package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS);
  - APB_ADDR_W = 7, APB_DATA_W = 8;
  - SLV_SEL_BIT = 7.
- One sub-module: apb_wait_timer (the timeout counter), instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write addr 0x12, data 0xA5 to a zero-wait slave 1 → PSELECT1 = 1 in cycles 1–2, PENABLE = 1 in cycle 2, rsp_valid in cycle 3, rsp_err = 0, rsp_rdata = 0.
- Read back addr 0x12 → rsp_rdata = 0xA5; PSELECT2 never asserts.
- Read addr 0x85 from slave 2 with PREADY2 held low for 3 cycles and PRDATA2 = 0x3C → ACCESS lasts 4 cycles; rsp_valid arrives in cycle 6 with rsp_rdata = 0x3C; PADDR = 0x05 throughout.
- Slave 1 returns PSLVERR1 = 1 with PREADY1 = 1 → rsp_err = 1; the next command is accepted in cycle 3.
- Macro defined, TIMEOUT_CYCLES = 4, PREADY never asserted → abort after 4 wait cycles with rsp_err = 1 and rsp_rdata = 0. Macro undefined → no rsp_valid after 100 cycles.
- PRESET asserted in the second ACCESS wait cycle → next cycle all APB outputs are 0, no rsp_valid is issued, and req_ready = 1.
